// File: rtl/lc3_decode_pkg.sv
// lc3_decode_pkg: LC-3 opcodes, control encodings and the reference opcode-to-control decode
package lc3_decode_pkg;
    typedef enum logic [3:0] {
        OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST   = 4'h3,
        OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR  = 4'h7,
        OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI  = 4'hB,
        OP_JMP = 4'hC, OP_RES = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
    } opcode_e;

    localparam logic [1:0] W_ALU = 2'd0;
    localparam logic [1:0] W_PC  = 2'd1;
    localparam logic [1:0] W_MEM = 2'd2;

    localparam logic [1:0] PC1_OFF11 = 2'b00;
    localparam logic [1:0] PC1_OFF9  = 2'b01;
    localparam logic [1:0] PC1_OFF6  = 2'b10;
    localparam logic [1:0] PC1_ZERO  = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    typedef struct packed {
        logic [1:0] alu_control;
        logic [1:0] pcselect1;
        logic       pcselect2;
        logic       op2select;
    } e_ctrl_t;

    typedef struct packed {
        e_ctrl_t    e;
        logic [1:0] w;
        logic       mem;
    } ctrl_t;

    // op2select is active-low on instr[5]: 1 picks VSR2, 0 picks imm5
    function automatic ctrl_t decode_ctrl(input logic [15:0] instr);
        ctrl_t c;
        c = '0;
        case (opcode_e'(instr[15:12]))
            OP_ADD: c.e = '{ALU_ADD, PC1_OFF11, 1'b0, ~instr[5]};
            OP_AND: c.e = '{ALU_AND, PC1_OFF11, 1'b0, ~instr[5]};
            OP_NOT: c.e = '{ALU_NOT, PC1_OFF11, 1'b0, 1'b1};
            OP_BR:  c.e = '{ALU_ADD, PC1_OFF9, 1'b1, 1'b0};
            OP_JMP: c.e = '{ALU_ADD, PC1_ZERO, 1'b0, 1'b0};
            OP_LD:  c = '{'{ALU_ADD, PC1_OFF9, 1'b1, 1'b0}, W_MEM, 1'b0};
            OP_LDR: c = '{'{ALU_ADD, PC1_OFF6, 1'b0, 1'b0}, W_MEM, 1'b0};
            OP_LDI: c = '{'{ALU_ADD, PC1_OFF9, 1'b1, 1'b0}, W_MEM, 1'b1};
            OP_LEA: c = '{'{ALU_ADD, PC1_OFF9, 1'b1, 1'b0}, W_PC, 1'b0};
            OP_ST:  c.e = '{ALU_ADD, PC1_OFF9, 1'b1, 1'b0};
            OP_STR: c.e = '{ALU_ADD, PC1_OFF6, 1'b0, 1'b0};
            OP_STI: c = '{'{ALU_ADD, PC1_OFF9, 1'b1, 1'b0}, W_ALU, 1'b1};
            default: c = '0;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/decode_ctrl_logic.sv
// decode_ctrl_logic: combinational opcode-to-control decode ahead of the decode register
module decode_ctrl_logic
    import lc3_decode_pkg::*;
(
    input  logic [15:0] instr,
    output e_ctrl_t     e_control,
    output logic [1:0]  w_control,
    output logic        mem_control
);
    assign {e_control, w_control, mem_control} = decode_ctrl(instr);
endmodule

// File: rtl/decode_stage.sv
// decode_stage: LC-3 decode stage registering the instruction, next PC and decoded controls
module decode_stage
    import lc3_decode_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_control,
    output logic [1:0]  W_control,
    output logic        mem_control
);
    e_ctrl_t    e_next;
    logic [1:0] w_next;
    logic       mem_next;

    // decoding from dout, not IR, keeps IR and its controls in the same cycle
    decode_ctrl_logic u_ctrl (
        .instr       (dout),
        .e_control   (e_next),
        .w_control   (w_next),
        .mem_control (mem_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            IR          <= '0;
            npc_out     <= '0;
            E_control   <= '0;
            W_control   <= '0;
            mem_control <= 1'b0;
        end else if (enable_decode) begin
            IR          <= dout;
            npc_out     <= npc_in;
            E_control   <= e_next;
            W_control   <= w_next;
            mem_control <= mem_next;
        end
    end
endmodule
